vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Sequences the single external 128 KB 8-bit asynchronous SRAM that holds the 320x240 byte-per-pixel framebuffer.
- Shares that SRAM between three requesters:
  - the video scan-out fetch, which has absolute priority;
  - the CPU host port (A);
  - the blitter host port (B).
- Converts pixel coordinates to linear addresses, drives the SRAM strobes and the bidirectional data-bus enable, and returns read data with single-cycle acknowledges.

Parameters:
- FB_WIDTH, 320, pixels per framebuffer line.
- FB_HEIGHT, 240, framebuffer lines.
- ADDR_WIDTH, 17, SRAM address width.

Ports:
- clock  in  1  system clock; every register updates on posedge.
- reset  in  1  synchronous, active-high.
- videoXCoord  in  9  video fetch x coordinate.
- videoYCoord  in  8  video fetch y coordinate.
- videoRequest  in  1  single-cycle pulse requesting a fetch at the video coordinates.
- videoData  out  8  fetched pixel.
- videoDataReady  out  1  single-cycle pulse; videoData is valid in that cycle.
- hostAXCoord / hostBXCoord  in  9  host pixel x coordinate.
- hostAYCoord / hostBYCoord  in  8  host pixel y coordinate.
- hostAReadRequest / hostBReadRequest  in  1  level; held until ack.
- hostAWriteRequest / hostBWriteRequest  in  1  level; held until ack.
- hostAWriteData / hostBWriteData  in  8  byte to write.
- hostAReadData / hostBReadData  out  8  read result; holds its value until the next read ack on the same port.
- hostAAck / hostBAck  out  1  single-cycle completion pulse.
- ramAddress  out  ADDR_WIDTH  SRAM address.
- ramDataOut  out  8  write data, driven onto the pad by the top level.
- ramDataDrive  out  1  pad tristate enable; 1 = drive ramDataOut.
- ramDataIn  in  8  pad input.
- ramOutputEnable  out  1  active-low SRAM OE.
- ramWriteEnable  out  1  active-low SRAM WE.

Behaviour:
- Reset values:
  - ramOutputEnable = 1, ramWriteEnable = 1, ramDataDrive = 0, ramAddress = 0.
  - All acks = 0, videoDataReady = 0, videoData = 0, both hostReadData = 0.
  - Video-pending flag cleared; round-robin pointer set so host A wins first.
  - Reset mid-access aborts the access: strobes go inactive on the reset edge; no ack or ready is issued for the aborted access.
- Address arithmetic: address = y*320 + x, computed as (y<<8)+(y<<6)+x at full ADDR_WIDTH with no truncation. Maximum legal address is 76799.
- Video capture: a videoRequest pulse latches its coordinates and sets video-pending.
  - A second pulse while pending overwrites the coordinates; only one fetch is issued.
  - Scan-out issues at most one request every 4 clocks.
- FSM states: IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_HOLD.
- IDLE arbitration, evaluated every cycle:
  1. Video-pending → RD_SETUP (video).
  2. Otherwise, the eligible host(s) with a read or write request; if both hosts request, the round-robin pointer picks.
  - Pointer update: it moves to the other host after every host grant.
  - Read and write asserted together on one port are treated as a write.
- Out-of-range host access (x >= FB_WIDTH or y >= FB_HEIGHT):
  - No SRAM cycle is issued.
  - The ack is pulsed from IDLE in the next cycle.
  - A read in this case returns 0x00.
  - Counts as a grant for round-robin.
- Out-of-range video coordinates return 0x00 with videoDataReady pulsed; there is no SRAM cycle.
- RD_SETUP (1 cycle): ramAddress driven, ramOutputEnable = 0, ramDataDrive = 0. Next state RD_SAMPLE.
- RD_SAMPLE (1 cycle): ramOutputEnable stays 0.
  - ramDataIn is registered at the end of this cycle.
  - Next cycle: videoDataReady or the host ack pulses, with data valid.
  - FSM returns to IDLE.
- WR_SETUP (1 cycle): ramAddress driven, ramDataDrive = 1, ramDataOut = write data, ramWriteEnable = 0.
- WR_HOLD (1 cycle): ramWriteEnable = 1; data and address are held with ramDataDrive still 1. Ack pulses in the following cycle; FSM returns to IDLE.
- ramOutputEnable and ramWriteEnable are never both 0 in the same cycle.
- ramDataDrive is never 1 while ramOutputEnable = 0.
- Latency, from request visible in IDLE to ack/ready:
  - 3 cycles for a read or write.
  - Video worst case 5 cycles from videoRequest, when a host access has just started.
- The ack is deasserted the cycle after it pulses. The host drops its request on the ack cycle; if the request is still high in the next IDLE cycle, it is treated as a new request.

Test Plan:
- Reset, then host A read at (0,0) with the SRAM model holding 0x5A → ramAddress = 0, OE low for 2 cycles, hostAAck one pulse 3 cycles later, hostAReadData = 0x5A.
- Host B write 0xC3 at (319,239) → ramAddress = 76799; WE low exactly 1 cycle with ramDataDrive=1 spanning it ±1 cycle; hostBAck pulse; readback returns 0xC3.
- Hosts A and B requesting continuously with a videoRequest every 4 clocks → every video fetch is ready within 5 cycles; host grants alternate A,B,A,B; OE and WE are never simultaneously 0.
- Host A read at x=320 → no OE/WE activity, ack next cycle, data 0x00; the round-robin pointer advances to B.
- Reset asserted during WR_SETUP → WE returns high on the reset edge; no ack; all outputs take their reset values.

Source files
------------

// File: rtl/vram_arbiter.sv
// Framebuffer SRAM sequencer shared by video scan-out (absolute priority)
// and two round-robin host ports, with pixel-to-linear address mapping.
module vram_arbiter #(
    parameter int unsigned FB_WIDTH   = 320,
    parameter int unsigned FB_HEIGHT  = 240,
    parameter int unsigned ADDR_WIDTH = 17
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [8:0]            videoXCoord,
    input  logic [7:0]            videoYCoord,
    input  logic                  videoRequest,
    output logic [7:0]            videoData,
    output logic                  videoDataReady,
    input  logic [8:0]            hostAXCoord,
    input  logic [7:0]            hostAYCoord,
    input  logic                  hostAReadRequest,
    input  logic                  hostAWriteRequest,
    input  logic [7:0]            hostAWriteData,
    output logic [7:0]            hostAReadData,
    output logic                  hostAAck,
    input  logic [8:0]            hostBXCoord,
    input  logic [7:0]            hostBYCoord,
    input  logic                  hostBReadRequest,
    input  logic                  hostBWriteRequest,
    input  logic [7:0]            hostBWriteData,
    output logic [7:0]            hostBReadData,
    output logic                  hostBAck,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic [7:0]            ramDataOut,
    output logic                  ramDataDrive,
    input  logic [7:0]            ramDataIn,
    output logic                  ramOutputEnable,
    output logic                  ramWriteEnable
);

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_HOLD
    } stateT;

    typedef enum logic [1:0] {
        OWNER_VIDEO, OWNER_A, OWNER_B
    } ownerT;

    stateT      state;
    ownerT      owner;
    logic       rrPointB;
    logic       videoPending;
    logic [8:0] pendX;
    logic [7:0] pendY;

    function automatic logic [ADDR_WIDTH-1:0] linearAddress(
        input logic [8:0] x,
        input logic [7:0] y
    );
        return (ADDR_WIDTH'(y) << 8) + (ADDR_WIDTH'(y) << 6)
             + ADDR_WIDTH'(x);
    endfunction

    function automatic logic inRange(
        input logic [8:0] x,
        input logic [7:0] y
    );
        return (32'(x) < FB_WIDTH) && (32'(y) < FB_HEIGHT);
    endfunction

    logic                  vidReq, vidOk;
    logic                  aReq, bReq, pickB, hostReq;
    logic                  selWrite, selOk;
    logic [8:0]            vidX, selX;
    logic [7:0]            vidY, selY, selData;
    logic [ADDR_WIDTH-1:0] vidAddr, selAddr;

    // A port whose ack is showing is still finishing; it is not eligible.
    always_comb begin
        vidReq   = videoRequest | videoPending;
        vidX     = videoRequest ? videoXCoord : pendX;
        vidY     = videoRequest ? videoYCoord : pendY;
        vidOk    = inRange(vidX, vidY);
        vidAddr  = linearAddress(vidX, vidY);
        aReq     = (hostAReadRequest | hostAWriteRequest) & ~hostAAck;
        bReq     = (hostBReadRequest | hostBWriteRequest) & ~hostBAck;
        pickB    = bReq & (~aReq | rrPointB);
        hostReq  = aReq | bReq;
        selX     = pickB ? hostBXCoord : hostAXCoord;
        selY     = pickB ? hostBYCoord : hostAYCoord;
        selWrite = pickB ? hostBWriteRequest : hostAWriteRequest;
        selData  = pickB ? hostBWriteData : hostAWriteData;
        selOk    = inRange(selX, selY);
        selAddr  = linearAddress(selX, selY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            owner           <= OWNER_VIDEO;
            rrPointB        <= 1'b0;
            videoPending    <= 1'b0;
            pendX           <= '0;
            pendY           <= '0;
            videoData       <= '0;
            videoDataReady  <= 1'b0;
            hostAReadData   <= '0;
            hostBReadData   <= '0;
            hostAAck        <= 1'b0;
            hostBAck        <= 1'b0;
            ramAddress      <= '0;
            ramDataOut      <= '0;
            ramDataDrive    <= 1'b0;
            ramOutputEnable <= 1'b1;
            ramWriteEnable  <= 1'b1;
        end else begin
            hostAAck       <= 1'b0;
            hostBAck       <= 1'b0;
            videoDataReady <= 1'b0;

            if (videoRequest && state != IDLE) begin
                videoPending <= 1'b1;
                pendX        <= videoXCoord;
                pendY        <= videoYCoord;
            end

            unique case (state)
                IDLE: begin
                    if (vidReq) begin
                        videoPending <= 1'b0;
                        owner        <= OWNER_VIDEO;
                        if (vidOk) begin
                            state           <= RD_SETUP;
                            ramAddress      <= vidAddr;
                            ramOutputEnable <= 1'b0;
                        end else begin
                            videoData      <= '0;
                            videoDataReady <= 1'b1;
                        end
                    end else if (hostReq) begin
                        rrPointB <= ~pickB;
                        owner    <= pickB ? OWNER_B : OWNER_A;
                        if (!selOk) begin
                            hostAAck <= ~pickB;
                            hostBAck <= pickB;
                            if (!selWrite && pickB)  hostBReadData <= '0;
                            if (!selWrite && !pickB) hostAReadData <= '0;
                        end else if (selWrite) begin
                            state          <= WR_SETUP;
                            ramAddress     <= selAddr;
                            ramDataOut     <= selData;
                            ramDataDrive   <= 1'b1;
                            ramWriteEnable <= 1'b0;
                        end else begin
                            state           <= RD_SETUP;
                            ramAddress      <= selAddr;
                            ramOutputEnable <= 1'b0;
                        end
                    end
                end
                RD_SETUP: state <= RD_SAMPLE;
                RD_SAMPLE: begin
                    state           <= IDLE;
                    ramOutputEnable <= 1'b1;
                    unique case (owner)
                        OWNER_A: begin
                            hostAReadData <= ramDataIn;
                            hostAAck      <= 1'b1;
                        end
                        OWNER_B: begin
                            hostBReadData <= ramDataIn;
                            hostBAck      <= 1'b1;
                        end
                        default: begin
                            videoData      <= ramDataIn;
                            videoDataReady <= 1'b1;
                        end
                    endcase
                end
                WR_SETUP: begin
                    state          <= WR_HOLD;
                    ramWriteEnable <= 1'b1;
                end
                WR_HOLD: begin
                    state        <= IDLE;
                    ramDataDrive <= 1'b0;
                    hostAAck     <= (owner == OWNER_A);
                    hostBAck     <= (owner == OWNER_B);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural async SRAM model.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  videoXCoord;
    logic [7:0]  videoYCoord;
    logic        videoRequest;
    logic [7:0]  videoData;
    logic        videoDataReady;
    logic [8:0]  hostAXCoord, hostBXCoord;
    logic [7:0]  hostAYCoord, hostBYCoord;
    logic        hostAReadRequest, hostBReadRequest;
    logic        hostAWriteRequest, hostBWriteRequest;
    logic [7:0]  hostAWriteData, hostBWriteData;
    logic [7:0]  hostAReadData, hostBReadData;
    logic        hostAAck, hostBAck;
    logic [16:0] ramAddress;
    logic [7:0]  ramDataOut;
    logic        ramDataDrive;
    logic [7:0]  ramDataIn;
    logic        ramOutputEnable;
    logic        ramWriteEnable;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:131071];

    always #5 clock = ~clock;

    assign ramDataIn = ramOutputEnable ? 8'h00 : mem[ramAddress];

    always @(negedge clock)
        if (!ramWriteEnable && ramDataDrive) mem[ramAddress] <= ramDataOut;

    vram_arbiter dut (
        .clock(clock), .reset(reset),
        .videoXCoord(videoXCoord), .videoYCoord(videoYCoord),
        .videoRequest(videoRequest), .videoData(videoData),
        .videoDataReady(videoDataReady),
        .hostAXCoord(hostAXCoord), .hostAYCoord(hostAYCoord),
        .hostAReadRequest(hostAReadRequest),
        .hostAWriteRequest(hostAWriteRequest),
        .hostAWriteData(hostAWriteData), .hostAReadData(hostAReadData),
        .hostAAck(hostAAck),
        .hostBXCoord(hostBXCoord), .hostBYCoord(hostBYCoord),
        .hostBReadRequest(hostBReadRequest),
        .hostBWriteRequest(hostBWriteRequest),
        .hostBWriteData(hostBWriteData), .hostBReadData(hostBReadData),
        .hostBAck(hostBAck),
        .ramAddress(ramAddress), .ramDataOut(ramDataOut),
        .ramDataDrive(ramDataDrive), .ramDataIn(ramDataIn),
        .ramOutputEnable(ramOutputEnable), .ramWriteEnable(ramWriteEnable)
    );

    task automatic idleInputs();
        videoXCoord = '0; videoYCoord = '0; videoRequest = 1'b0;
        hostAXCoord = '0; hostAYCoord = '0; hostAWriteData = '0;
        hostBXCoord = '0; hostBYCoord = '0; hostBWriteData = '0;
        hostAReadRequest = 1'b0; hostAWriteRequest = 1'b0;
        hostBReadRequest = 1'b0; hostBWriteRequest = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idleInputs();
        repeat (2) @(negedge clock);
        total++;
        if ({ramOutputEnable, ramWriteEnable, ramDataDrive} !== 3'b110) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=110",
                     {ramOutputEnable, ramWriteEnable, ramDataDrive});
        end
        total++;
        if (ramAddress !== 17'd0) begin
            bad++; $display("FAIL reset_addr got=%0d want=0", ramAddress);
        end
        total++;
        if ({hostAAck, hostBAck, videoDataReady} !== 3'b000) begin
            bad++;
            $display("FAIL reset_pulses got=%b want=000",
                     {hostAAck, hostBAck, videoDataReady});
        end
        total++;
        if ({videoData, hostAReadData, hostBReadData} !== 24'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=000000",
                     {videoData, hostAReadData, hostBReadData});
        end
        reset = 1'b0;
    endtask

    task automatic test_host_a_read();
        int oeLow = 0;
        int ackAt = -1;
        int ackCnt = 0;
        logic [16:0] addrSeen = '1;
        logic [7:0] dataSeen = '0;
        mem[0] = 8'h5A;
        hostAXCoord = 9'd0; hostAYCoord = 8'd0; hostAReadRequest = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (!ramOutputEnable) begin oeLow++; addrSeen = ramAddress; end
            if (hostAAck) begin
                ackCnt++;
                if (ackAt < 0) ackAt = c;
                dataSeen = hostAReadData;
                hostAReadRequest = 1'b0;
            end
        end
        hostAReadRequest = 1'b0;
        total++;
        if (addrSeen !== 17'd0) begin
            bad++; $display("FAIL a_read_addr got=%0d want=0", addrSeen);
        end
        total++;
        if (oeLow != 2) begin
            bad++; $display("FAIL a_read_oe_cycles got=%0d want=2", oeLow);
        end
        total++;
        if (ackAt != 3 || ackCnt != 1) begin
            bad++;
            $display("FAIL a_read_ack got=cycle%0d/x%0d want=cycle3/x1",
                     ackAt, ackCnt);
        end
        total++;
        if (dataSeen !== 8'h5A) begin
            bad++; $display("FAIL a_read_data got=%h want=5a", dataSeen);
        end
    endtask

    task automatic test_host_b_write();
        int weLow = 0, weAt = -1, oeLow = 0;
        int drvFirst = -1, drvLast = -1, ackAt = -1;
        logic [16:0] addrSeen = '0;
        logic [7:0] dataSeen = '0;
        hostBXCoord = 9'd319; hostBYCoord = 8'd239;
        hostBWriteData = 8'hC3; hostBWriteRequest = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (!ramOutputEnable) oeLow++;
            if (!ramWriteEnable) begin
                weLow++; weAt = c; addrSeen = ramAddress;
            end
            if (ramDataDrive) begin
                if (drvFirst < 0) drvFirst = c;
                drvLast = c;
            end
            if (hostBAck && ackAt < 0) begin
                ackAt = c; hostBWriteRequest = 1'b0;
            end
        end
        total++;
        if (addrSeen !== 17'd76799) begin
            bad++; $display("FAIL b_write_addr got=%0d want=76799", addrSeen);
        end
        total++;
        if (weLow != 1 || weAt != 1 || oeLow != 0) begin
            bad++;
            $display("FAIL b_write_we got=%0d@%0d oe=%0d want=1@1 oe=0",
                     weLow, weAt, oeLow);
        end
        total++;
        if (drvFirst != 1 || drvLast != 2) begin
            bad++;
            $display("FAIL b_write_drive got=%0d..%0d want=1..2",
                     drvFirst, drvLast);
        end
        total++;
        if (ackAt != 3) begin
            bad++; $display("FAIL b_write_ack got=%0d want=3", ackAt);
        end
        ackAt = -1;
        hostBReadRequest = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (hostBAck && ackAt < 0) begin
                ackAt = c; dataSeen = hostBReadData; hostBReadRequest = 1'b0;
            end
        end
        total++;
        if (ackAt != 3 || dataSeen !== 8'hC3) begin
            bad++;
            $display("FAIL b_readback got=%h@%0d want=c3@3", dataSeen, ackAt);
        end
    endtask

    task automatic test_out_of_range();
        int act = 0, ackAt = -1, aAt = -1, bAt = -1;
        logic [7:0] aData = '1, bData = '0;
        mem[1] = 8'h11; mem[2] = 8'h22;
        hostAXCoord = 9'd320; hostAYCoord = 8'd0; hostAReadRequest = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            if (!ramOutputEnable || !ramWriteEnable) act++;
            if (hostAAck && ackAt < 0) begin
                ackAt = c; aData = hostAReadData; hostAReadRequest = 1'b0;
            end
        end
        total++;
        if (act != 0 || ackAt != 1) begin
            bad++;
            $display("FAIL oor_timing got=act%0d ack@%0d want=act0 ack@1",
                     act, ackAt);
        end
        total++;
        if (aData !== 8'h00) begin
            bad++; $display("FAIL oor_data got=%h want=00", aData);
        end
        hostAXCoord = 9'd1; hostBXCoord = 9'd2; hostBYCoord = 8'd0;
        hostAReadRequest = 1'b1; hostBReadRequest = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (hostAAck && aAt < 0) begin
                aAt = c; aData = hostAReadData; hostAReadRequest = 1'b0;
            end
            if (hostBAck && bAt < 0) begin
                bAt = c; bData = hostBReadData; hostBReadRequest = 1'b0;
            end
        end
        total++;
        if (bAt != 3 || aAt != 6) begin
            bad++;
            $display("FAIL rr_after_oor got=B@%0d A@%0d want=B@3 A@6",
                     bAt, aAt);
        end
        total++;
        if (aData !== 8'h11 || bData !== 8'h22) begin
            bad++;
            $display("FAIL rr_data got=%h/%h want=11/22", aData, bData);
        end
    endtask

    task automatic test_video_boundary();
        int rdyAt = -1;
        logic [7:0] d = '0;
        videoXCoord = 9'd319; videoYCoord = 8'd239; videoRequest = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            videoRequest = 1'b0;
            if (videoDataReady && rdyAt < 0) begin rdyAt = c; d = videoData; end
        end
        total++;
        if (rdyAt != 3 || d !== 8'hC3) begin
            bad++;
            $display("FAIL video_corner got=%h@%0d want=c3@3", d, rdyAt);
        end
        rdyAt = -1; d = '1;
        videoXCoord = 9'd5; videoYCoord = 8'd240; videoRequest = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            videoRequest = 1'b0;
            if (!ramOutputEnable) rdyAt = 99;
            if (videoDataReady && rdyAt < 0) begin rdyAt = c; d = videoData; end
        end
        total++;
        if (rdyAt != 1 || d !== 8'h00) begin
            bad++;
            $display("FAIL video_oor got=%h@%0d want=00@1", d, rdyAt);
        end
    endtask

    task automatic test_contention();
        int vq[$];
        logic [7:0] vd[$];
        int lastHost = -1, altBad = 0, latBad = 0, overlap = 0;
        int readyCnt = 0, aCnt = 0, bCnt = 0, p, k;
        logic [7:0] e;
        for (int i = 0; i < 8; i++) mem[8 + i] = 8'hA0 + 8'(i);
        hostAXCoord = 9'd1; hostAYCoord = 8'd0; hostAReadRequest = 1'b1;
        hostBXCoord = 9'd2; hostBYCoord = 8'd0; hostBReadRequest = 1'b1;
        videoYCoord = 8'd0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clock);
            if (!ramOutputEnable && !ramWriteEnable) overlap++;
            if (ramDataDrive && !ramOutputEnable) overlap++;
            if (videoDataReady) begin
                readyCnt++;
                if (vq.size() == 0) latBad++;
                else begin
                    p = vq.pop_front(); e = vd.pop_front();
                    if (c - p > 5 || videoData !== e) latBad++;
                end
            end
            if (hostAAck) begin
                aCnt++;
                if (lastHost == 0 || hostAReadData !== 8'h11) altBad++;
                lastHost = 0;
            end
            if (hostBAck) begin
                bCnt++;
                if (lastHost == 1 || hostBReadData !== 8'h22) altBad++;
                lastHost = 1;
            end
            videoRequest = (c % 4 == 0) && (c < 40);
            if (videoRequest) begin
                k = (c / 4) % 8;
                videoXCoord = 9'd8 + 9'(k);
                vq.push_back(c);
                vd.push_back(8'hA0 + 8'(k));
            end
        end
        videoRequest = 1'b0;
        hostAReadRequest = 1'b0; hostBReadRequest = 1'b0;
        repeat (6) @(negedge clock);
        total++;
        if (overlap != 0) begin
            bad++; $display("FAIL strobe_overlap got=%0d want=0", overlap);
        end
        total++;
        if (latBad != 0 || readyCnt != 10) begin
            bad++;
            $display("FAIL video_latency got=bad%0d rdy%0d want=bad0 rdy10",
                     latBad, readyCnt);
        end
        total++;
        if (altBad != 0 || aCnt < 2 || bCnt < 2) begin
            bad++;
            $display("FAIL host_alternate got=bad%0d a%0d b%0d want=bad0 a>=2 b>=2",
                     altBad, aCnt, bCnt);
        end
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        hostAXCoord = 9'd4; hostAYCoord = 8'd0;
        hostAWriteData = 8'h77; hostAWriteRequest = 1'b1;
        @(negedge clock);
        total++;
        if (ramWriteEnable !== 1'b0) begin
            bad++; $display("FAIL mid_wr_setup got=%b want=0", ramWriteEnable);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({ramOutputEnable, ramWriteEnable, ramDataDrive} !== 3'b110
            || ramAddress !== 17'd0) begin
            bad++;
            $display("FAIL mid_reset_strobes got=%b/%0d want=110/0",
                     {ramOutputEnable, ramWriteEnable, ramDataDrive},
                     ramAddress);
        end
        total++;
        if ({videoData, hostAReadData, hostBReadData} !== 24'h0) begin
            bad++;
            $display("FAIL mid_reset_data got=%h want=000000",
                     {videoData, hostAReadData, hostBReadData});
        end
        reset = 1'b0;
        hostAWriteRequest = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (hostAAck || hostBAck || videoDataReady) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++; $display("FAIL mid_reset_no_ack got=%0d want=0", acks);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_host_a_read();
        test_host_b_write();
        test_out_of_range();
        test_video_boundary();
        test_contention();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
